// File: rtl/pes_pwm_multi.sv
// Multi-channel edge-aligned PWM with debounced per-channel inc/dec duty buttons.
// Optional complementary outputs with dead time when PES_PWM_DEADTIME_EN is defined.
module pes_pwm_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned STEPS        = 10,
  parameter int unsigned INIT_DUTY    = 5,
  parameter int unsigned PWM_PRESCALE = 1,
  parameter int unsigned DEBOUNCE_DIV = 2,
`ifdef PES_PWM_DEADTIME_EN
  parameter int unsigned DEADTIME     = 2,
`endif
  localparam int unsigned DW = $clog2(STEPS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHANNELS-1:0]    inc_duty,
  input  logic [CHANNELS-1:0]    dec_duty,
  output logic [CHANNELS-1:0]    pwm_out,
`ifdef PES_PWM_DEADTIME_EN
  output logic [CHANNELS-1:0]    pwm_out_n,
`endif
  output logic [CHANNELS*DW-1:0] duty_level,
  output logic                   period_start
);

  localparam int unsigned CW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PW  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int unsigned DDW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DDW-1:0]      div_q, div_d;
  logic                pwm_tick, wrap, sample_tick;
  logic [CHANNELS-1:0] s1_inc_q, s2_inc_q, s1_dec_q, s2_dec_q;
  logic [CHANNELS-1:0] press_inc, press_dec;
  logic [DW-1:0]       shadow_q [CHANNELS];
  logic [DW-1:0]       shadow_d [CHANNELS];
  logic [DW-1:0]       active_q [CHANNELS];
  logic [DW-1:0]       active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q;

  always_comb begin
    pwm_tick    = (presc_q == PW'(PWM_PRESCALE - 1));
    wrap        = pwm_tick && (cnt_q == CW'(STEPS - 1));
    sample_tick = (div_q == DDW'(DEBOUNCE_DIV - 1));
    presc_d     = pwm_tick ? '0 : presc_q + 1'b1;
    div_d       = sample_tick ? '0 : div_q + 1'b1;
    cnt_d       = cnt_q;
    if (pwm_tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    press_inc   = s1_inc_q & ~s2_inc_q & {CHANNELS{sample_tick}};
    press_dec   = s1_dec_q & ~s2_dec_q & {CHANNELS{sample_tick}};
    duty_level  = '0;
    pwm_d       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (press_inc[i] && !press_dec[i] && (shadow_q[i] < DW'(STEPS))) begin
        shadow_d[i] = shadow_q[i] + 1'b1;
      end else if (press_dec[i] && !press_inc[i] && (shadow_q[i] != '0)) begin
        shadow_d[i] = shadow_q[i] - 1'b1;
      end
      // New duty is visible on the first count of the new period.
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
      pwm_d[i]    = (32'(cnt_d) < 32'(active_d[i]));
      duty_level[i*DW +: DW] = active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      div_q          <= '0;
      s1_inc_q       <= '0;
      s2_inc_q       <= '0;
      s1_dec_q       <= '0;
      s2_dec_q       <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= DW'(INIT_DUTY);
        active_q[i] <= DW'(INIT_DUTY);
      end
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      pwm_q          <= pwm_d;
      period_start_q <= wrap;
      if (sample_tick) begin
        s1_inc_q <= inc_duty;
        s2_inc_q <= s1_inc_q;
        s1_dec_q <= dec_duty;
        s2_dec_q <= s1_dec_q;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign period_start = period_start_q;

`ifdef PES_PWM_DEADTIME_EN
  localparam int unsigned RW = $clog2(DEADTIME + 2);

  // Length of the current raw level run, saturating just past DEADTIME.
  logic [RW-1:0] run_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (pwm_d[i] != pwm_q[i]) begin
          run_q[i] <= RW'(1);
        end else if (32'(run_q[i]) <= DEADTIME) begin
          run_q[i] <= run_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pwm_out   = '0;
    pwm_out_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_out[i]   = pwm_q[i] && (32'(run_q[i]) > DEADTIME);
      pwm_out_n[i] = !pwm_q[i] && (32'(run_q[i]) > DEADTIME);
    end
  end
`else
  assign pwm_out = pwm_q;
`endif

endmodule

// File: doc/pes_pwm_multi.md
Name: pes_pwm_multi

Overview:
Multi-channel PWM generator with per-channel push-button duty control.
- CHANNELS independent outputs share one period counter, so all outputs are edge-aligned.
- Each channel has debounced increase/decrease buttons that step its duty in 1/STEPS increments.
- Duty changes take effect only at a period boundary, so no output pulse is ever truncated or glitched.
- Sits between board push-buttons and motor/LED drivers; generalises the single-channel 10-step PWM block.

Parameters:
- CHANNELS, 4, number of PWM outputs and button pairs.
- STEPS, 10, duty resolution and period length in PWM ticks; legal duty values are 0..STEPS.
- INIT_DUTY, 5, duty loaded into every channel at reset; must be <= STEPS.
- PWM_PRESCALE, 1, clk cycles per PWM tick (1 means the period counter advances every clk).
- DEBOUNCE_DIV, 2, clk cycles per debounce sample tick (simulation value; use 25000000 on FPGA).
- DW, $clog2(STEPS+1), width of each duty field (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- inc_duty  in  CHANNELS  raw increase buttons, bit i belongs to channel i.
- dec_duty  in  CHANNELS  raw decrease buttons.
- pwm_out  out  CHANNELS  registered PWM outputs.
- duty_level  out  CHANNELS*DW  active duty per channel, channel i at [i*DW +: DW].
- period_start  out  1  one-clk pulse on the first clk of each PWM period.

Behaviour:
- Reset (rst_n=0 at a clk edge): all counters = 0, debounce flops = 0, shadow and active duty = INIT_DUTY, pwm_out = 0, period_start = 0.
- Prescaler: counts 0..PWM_PRESCALE-1 and wraps. pwm_tick is high when the prescaler = PWM_PRESCALE-1; with PWM_PRESCALE=1, pwm_tick is always high.
- Period counter: advances on pwm_tick through 0..STEPS-1, then wraps to 0.
- wrap: high when pwm_tick=1 and the period counter = STEPS-1.
- Debounce divider: counts 0..DEBOUNCE_DIV-1 and wraps. sample_tick is high when the divider = DEBOUNCE_DIV-1.
- Per-channel debounce: on sample_tick, s1 <= button and s2 <= s1. press = s1 & ~s2 & sample_tick, giving exactly one clk pulse per press.
- Shadow duty update, per channel:
  - press_inc only and shadow < STEPS: shadow + 1.
  - press_dec only and shadow > 0: shadow - 1.
  - Both presses in the same clk: no change.
  - Already at the limit: no change (saturate, never wrap).
- Active duty: on the clk where wrap=1, active <= shadow for every channel. A shadow update in that same clk is not transferred; it waits for the next wrap.
- pwm_out[i] <= (next period count < active[i]), registered, so the output aligns with the period count with no lag.
  - Duty 0: constant low.
  - Duty STEPS: constant high.
  - Otherwise: high for the first duty×PWM_PRESCALE clks of each period.
- period_start: registered copy of wrap, coincident with period count 0 at the output.
- duty_level: reflects the active duty, not the shadow.
- Reset mid-period: outputs are forced low on the next edge; the period restarts from count 0 once rst_n=1.

Optional Feature:
- Macro PES_PWM_DEADTIME_EN.
- When defined:
  - Adds parameter DEADTIME (default 2, in clk) and output pwm_out_n[CHANNELS].
  - pwm_out rises DEADTIME clks after the raw PWM rises.
  - pwm_out_n rises DEADTIME clks after the raw PWM falls.
  - Both outputs fall immediately with their raw level, so both are low during the dead band.
  - A raw high or low pulse shorter than or equal to DEADTIME clks suppresses the corresponding output for that pulse.
  - Both outputs are never high in the same clk.
- When undefined: no pwm_out_n port, no dead-time logic, and pwm_out behaves as described above.

Test Plan:
1. Reset with defaults, no buttons pressed: every channel has pwm_out high 5 clks then low 5 clks, repeating; period_start pulses every 10 clks; duty_level = 5.
2. One press on inc_duty[0] held for 4 clks mid-period: shadow0 = 6 once; pwm_out[0] is unchanged until the next period_start, then high 6 of 10 clks; channels 1-3 stay at 5.
3. Six separate dec_duty[1] presses: duty stops at 0 (saturates, no wrap) and pwm_out[1] is constantly low; then eleven inc presses: duty stops at 10 and the output is constantly high.
4. inc_duty[2] and dec_duty[2] rising in the same clk: press pulses coincide and duty stays at 5.
5. PWM_PRESCALE=3, duty 5: pwm_out high 15 clks, low 15 clks; period_start every 30 clks. Asserting rst_n=0 mid-high forces outputs low on the next edge.
6. With PES_PWM_DEADTIME_EN and DEADTIME=2, duty 5: pwm_out high 3 clks, pwm_out_n high 3 clks, 2-clk dead bands between them; at duty 1, pwm_out never goes high.
